pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output, producing sum, carry-out and signed overflow. The WIDTH-bit operation is split into STAGES equal carry-chained slices, one slice resolved per pipeline stage, so wide adders close timing at high clock rates. It is the drop-in registered replacement for the combinational full adder in datapaths that need throughput of one operation per clock with backpressure.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b (computed as a+~b+1, cin ignored).
- out_valid  output  1  result bundle valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result bits [WIDTH-1:0].
- cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operand B' = sub ? ~b : b; effective carry-in c0 = sub ? 1 : cin. All arithmetic is modulo 2^WIDTH; the full (WIDTH+1)-bit result is {cout, sum}.
- Stage s (1..STAGES) adds slice s-1 (bits [s*SW-1:(s-1)*SW]) of a and B' plus the registered carry from stage s-1 (c0 for stage 1); it registers the SW-bit partial sum, the slice carry, every already-resolved lower slice, and the still-unused upper slices of a and B'.
- Stage STAGES additionally registers the carry into bit WIDTH-1 to form ovf.
- Each stage holds a valid bit; the result registers of stage STAGES drive sum/cout/ovf/out_valid directly (no combinational path from a/b to outputs).
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. When adv=1 all stages shift by one (stage 1 loads in_valid && in_ready bundle; invalid bundles propagate as bubbles). When adv=0 all stages hold.
- Bubbles are not squeezed out; a bubble inside the pipe occupies its slot until adv advances it.
- STAGES=1 degenerates to a single registered full-width adder.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0; sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 from the first cycle after reset. Reset asserted mid-operation discards all in-flight bundles immediately; no partial result is ever presented.
- Latency: a bundle accepted at rising edge t (in_valid && in_ready sampled high) appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES edges inclusive of the accept edge.
- Throughput: one bundle per clock while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold unchanged and in_ready=0; inputs are not sampled.
- Same-cycle out_ready=1 with full pipe: result drains and a new bundle is accepted on the same edge (in_ready=1 combinationally from out_ready).
- in_ready depends combinationally on out_ready only; out_valid/sum/cout/ovf are pure register outputs.
- Operand changes while in_valid=0 or in_ready=0 have no effect.

## Test plan
- Reset/latency, WIDTH=32 STAGES=4: single bundle a=0x0000_0001 b=0x0000_0002 cin=0 sub=0, out_ready=1 -> out_valid first high 4 edges after accept, sum=0x0000_0003 cout=0 ovf=0; out_valid=0, sum=0 during and after reset.
- Cross-slice carry: a=0xFFFF_FFFF b=0x0000_0000 cin=1 -> sum=0x0000_0000 cout=1 ovf=0; a=0x7FFF_FFFF b=1 cin=0 -> sum=0x8000_0000 cout=0 ovf=1.
- Subtract: a=5 b=7 sub=1 cin=1 -> sum=0xFFFF_FFFE cout=0 ovf=0; a=0x8000_0000 b=1 sub=1 -> sum=0x7FFF_FFFF cout=1 ovf=1.
- Backpressure: stream 10 back-to-back random bundles, out_ready toggled in a 1-high/2-low pattern -> every result matches a golden model in order, none lost or duplicated, outputs stable while out_ready=0, in_ready=0 exactly when out_valid=1 and out_ready=0.
- Reset mid-stream: 3 bundles in flight, pulse rst_n low for 1 cycle asynchronously -> out_valid drops immediately, none of the 3 results ever appear; next bundle after reset returns correctly with 4-cycle latency.
- Parameter sweep: WIDTH/STAGES = 8/1, 16/2, 64/8, 10000 random bundles each with random in_valid/out_ready -> results match the model and latency equals STAGES.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: two's-complement adder/subtractor split into STAGES
// carry-chained slices of SW = WIDTH/STAGES bits, one slice per stage,
// with valid/ready handshakes and a global advance enable.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   a, b, cin, sub       operands; sub=1 computes a-b, cin ignored
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       registered result, carry out, signed overflow
//
// WIDTH must be a multiple of STAGES, and STAGES must be 1..WIDTH.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int          NS = int'(STAGES);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipe moves together; it only stalls behind an unaccepted result.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction as a + ~b + 1.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  for (genvar s = 0; s < NS; s++) begin : g_st
    localparam int unsigned LO = s * SW;   // lowest bit resolved here
    localparam int unsigned HI = LO + SW;  // bits resolved after this stage

    logic [SW-1:0] op_a;
    logic [SW-1:0] op_b;
    logic          c_in;
    logic [SW:0]   slice;

    logic          vld_d, vld_q;
    logic          cy_q;
    logic [HI-1:0] res_d, res_q;

    // Operand slice source: primary inputs for the first stage, otherwise
    // the lowest still-unused slice carried by the previous stage.
    if (s == 0) begin : g_first
      assign op_a  = a[SW-1:0];
      assign op_b  = b_eff[SW-1:0];
      assign c_in  = c0;
      assign vld_d = in_valid;
      assign res_d = slice[SW-1:0];
    end else begin : g_next
      assign op_a  = g_st[s-1].g_up.ua_q[SW-1:0];
      assign op_b  = g_st[s-1].g_up.ub_q[SW-1:0];
      assign c_in  = g_st[s-1].cy_q;
      assign vld_d = g_st[s-1].vld_q;
      assign res_d = {slice[SW-1:0], g_st[s-1].res_q};
    end

    assign slice = {1'b0, op_a} + {1'b0, op_b} + {{SW{1'b0}}, c_in};

    // Valid, slice carry-out and the resolved low bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        cy_q  <= slice[SW];
        res_q <= res_d;
      end
    end

    // Upper slices of a and b' still waiting for their stage.
    if (s < NS - 1) begin : g_up
      logic [WIDTH-HI-1:0] ua_d, ua_q;
      logic [WIDTH-HI-1:0] ub_d, ub_q;

      if (s == 0) begin : g_src_in
        assign ua_d = a[WIDTH-1:SW];
        assign ub_d = b_eff[WIDTH-1:SW];
      end else begin : g_src_prev
        assign ua_d = g_st[s-1].g_up.ua_q[WIDTH-LO-1:SW];
        assign ub_d = g_st[s-1].g_up.ub_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ua_q <= '0;
          ub_q <= '0;
        end else if (adv) begin
          ua_q <= ua_d;
          ub_q <= ub_d;
        end
      end
    end

    // Overflow: carry into the MSB (recovered from the MSB sum bit) XOR carry out.
    if (s == NS - 1) begin : g_last
      logic ovf_d, ovf_q;

      assign ovf_d = slice[SW] ^ (slice[SW-1] ^ op_a[SW-1] ^ op_b[SW-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_st[NS-1].vld_q;
  assign sum       = g_st[NS-1].res_q;
  assign cout      = g_st[NS-1].cy_q;
  assign ovf       = g_st[NS-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors and a backpressure stream on a
// 32/4 instance, plus a random sweep over 32/4, 8/1, 16/2 and 64/8 instances
// checked against a scoreboard of expected results and arrival times.
module tb_pipelined_adder;

  localparam int NI  = 4;
  localparam int NSW = 10000;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          tag;   // advance count at which the result must be visible
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        tiv   [NI];
  logic        tordy [NI];
  logic [63:0] ta    [NI];
  logic [63:0] tbv   [NI];
  logic        tci   [NI];
  logic        tsub  [NI];

  logic        ir  [NI];
  logic        ov  [NI];
  logic        co  [NI];
  logic        ofl [NI];
  logic [63:0] sm  [NI];

  int          wd      [NI];
  int          st      [NI];
  int          adv_cnt [NI];
  exp_t        sbq     [NI][$];

  int vectors;
  int miscompares;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;
  logic [31:0] sum0;
  logic [7:0]  sum1;
  logic [15:0] sum2;
  logic [63:0] sum3;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(tiv[0]), .in_ready(ir0),
    .a(ta[0][31:0]), .b(tbv[0][31:0]), .cin(tci[0]), .sub(tsub[0]),
    .out_valid(ov0), .out_ready(tordy[0]), .sum(sum0), .cout(co0), .ovf(of0));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(tiv[1]), .in_ready(ir1),
    .a(ta[1][7:0]), .b(tbv[1][7:0]), .cin(tci[1]), .sub(tsub[1]),
    .out_valid(ov1), .out_ready(tordy[1]), .sum(sum1), .cout(co1), .ovf(of1));

  pipelined_adder #(.WIDTH(16), .STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(tiv[2]), .in_ready(ir2),
    .a(ta[2][15:0]), .b(tbv[2][15:0]), .cin(tci[2]), .sub(tsub[2]),
    .out_valid(ov2), .out_ready(tordy[2]), .sum(sum2), .cout(co2), .ovf(of2));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(tiv[3]), .in_ready(ir3),
    .a(ta[3]), .b(tbv[3]), .cin(tci[3]), .sub(tsub[3]),
    .out_valid(ov3), .out_ready(tordy[3]), .sum(sum3), .cout(co3), .ovf(of3));

  always_comb begin
    ir[0] = ir0;  ir[1] = ir1;  ir[2] = ir2;  ir[3] = ir3;
    ov[0] = ov0;  ov[1] = ov1;  ov[2] = ov2;  ov[3] = ov3;
    co[0] = co0;  co[1] = co1;  co[2] = co2;  co[3] = co3;
    ofl[0] = of0; ofl[1] = of1; ofl[2] = of2; ofl[3] = of3;
    sm[0] = 64'(sum0); sm[1] = 64'(sum1); sm[2] = 64'(sum2); sm[3] = sum3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain (WIDTH+1)-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(int i, logic [63:0] av, logic [63:0] bv, logic c, logic s);
    exp_t        e;
    logic [64:0] mask, am, bm, r;
    int          w;
    w    = wd[i];
    mask = (65'd1 << w) - 65'd1;
    am   = {1'b0, av} & mask;
    bm   = {1'b0, (s ? ~bv : bv)} & mask;
    r    = am + bm + {64'd0, (s ? 1'b1 : c)};
    e.sum  = 64'(r & mask);
    e.cout = r[w];
    e.ovf  = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    e.tag  = 0;
    return e;
  endfunction

  // Random operand biased toward the width's corner values.
  function automatic logic [63:0] rnd_op(int i);
    logic [63:0] m;
    logic [63:0] v;
    m = (wd[i] == 64) ? '1 : ((64'd1 << wd[i]) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = m;
      2:       v = m >> 1;
      3:       v = (m >> 1) + 64'd1;
      default: v = {$urandom, $urandom} & m;
    endcase
    return v;
  endfunction

  // Record accepted bundles for every instance, then advance one clock.
  task automatic tick();
    logic adv_b;
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      adv_b = !ov[i] || tordy[i];
      if (adv_b) begin
        adv_cnt[i]++;
        if (tiv[i]) begin
          e     = model(i, ta[i], tbv[i], tci[i], tsub[i]);
          e.tag = adv_cnt[i] + st[i] - 1;
          sbq[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", ov[0]); end
    vectors++; if (sm[0] !== 64'd0) begin miscompares++; $display("FAIL reset_sum got %h want 0", sm[0]); end
    vectors++; if ({co[0], ofl[0]} !== 2'b00) begin miscompares++; $display("FAIL reset_cout_ovf got %b%b want 00", co[0], ofl[0]); end
    vectors++; if ({ov[1], ov[2], ov[3]} !== 3'b000) begin miscompares++; $display("FAIL reset_sweep_valid got %b%b%b want 000", ov[1], ov[2], ov[3]); end
    rst_n    = 1'b1;
    tordy[0] = 1'b0;
    @(negedge clk);
    #1;
    vectors++; if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got %b want 0", ov[0]); end
    vectors++; if (sm[0] !== 64'd0) begin miscompares++; $display("FAIL post_reset_sum got %h want 0", sm[0]); end
    vectors++; if (ir[0] !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", ir[0]); end
    tordy[0] = 1'b1;
    @(negedge clk);
  endtask

  // One bundle through the 32/4 instance against fixed expected values.
  task automatic test_single(input string name, input logic [31:0] av, input logic [31:0] bv,
                             input logic c, input logic s, input logic [31:0] es,
                             input logic ec, input logic eo);
    int n;
    tiv[0] = 1'b1; ta[0] = 64'(av); tbv[0] = 64'(bv); tci[0] = c; tsub[0] = s; tordy[0] = 1'b1;
    #1;
    tick();
    n = 1;
    // Garbage operands after acceptance must not disturb the result.
    tiv[0] = 1'b0; ta[0] = '1; tbv[0] = '1; tci[0] = ~c; tsub[0] = ~s;
    while (n < 12) begin
      #1;
      if (ov[0]) break;
      tick();
      n++;
    end
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL %s latency got %0d edges want 4", name, n); end
    vectors++; if (sm[0] !== 64'(es)) begin miscompares++; $display("FAIL %s sum got %h want %h", name, sm[0], es); end
    vectors++; if (co[0] !== ec) begin miscompares++; $display("FAIL %s cout got %b want %b", name, co[0], ec); end
    vectors++; if (ofl[0] !== eo) begin miscompares++; $display("FAIL %s ovf got %b want %b", name, ofl[0], eo); end
    tick();
    sbq[0].delete();
  endtask

  task automatic test_latency();
    test_single("add_small", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
  endtask

  task automatic test_carry();
    test_single("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    test_single("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_subtract();
    test_single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    test_single("sub_overflow", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [63:0] cur_a, cur_b, snap_s;
    logic        cur_c, cur_s, snap_c, snap_o, stall_q, adv_b, acc;
    int          sent, got, c;
    exp_t        e;
    sent = 0; got = 0; c = 0; stall_q = 1'b0;
    snap_s = '0; snap_c = 1'b0; snap_o = 1'b0;
    cur_a = rnd_op(0); cur_b = rnd_op(0);
    cur_c = 1'($urandom_range(0, 1)); cur_s = 1'($urandom_range(0, 1));
    while ((sent < 10 || sbq[0].size() > 0 || ov[0]) && c < 200) begin
      tiv[0] = (sent < 10); ta[0] = cur_a; tbv[0] = cur_b; tci[0] = cur_c; tsub[0] = cur_s;
      tordy[0] = (c % 3 == 0);
      #1;
      adv_b = !ov[0] || tordy[0];
      vectors++; if (ir[0] !== adv_b) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want %b", c, ir[0], adv_b); end
      if (stall_q) begin
        vectors++;
        if ({ov[0], sm[0], co[0], ofl[0]} !== {1'b1, snap_s, snap_c, snap_o}) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                   c, ov[0], sm[0], co[0], ofl[0], snap_s, snap_c, snap_o);
        end
      end
      if (ov[0] && tordy[0]) begin
        vectors++;
        if (sbq[0].size() == 0) begin
          miscompares++; $display("FAIL bp_spurious cycle %0d got result %h want none", c, sm[0]);
        end else begin
          e = sbq[0].pop_front();
          got++;
          if ({sm[0], co[0], ofl[0]} !== {e.sum, e.cout, e.ovf}) begin
            miscompares++;
            $display("FAIL bp_result %0d got s=%h c=%b o=%b want s=%h c=%b o=%b", got, sm[0], co[0], ofl[0], e.sum, e.cout, e.ovf);
          end
          vectors++; if (adv_cnt[0] !== e.tag) begin miscompares++; $display("FAIL bp_latency %0d got adv %0d want %0d", got, adv_cnt[0], e.tag); end
        end
      end
      stall_q = ov[0] && !tordy[0];
      snap_s = sm[0]; snap_c = co[0]; snap_o = ofl[0];
      acc = tiv[0] && adv_b;
      tick();
      if (acc) begin
        sent++;
        cur_a = rnd_op(0); cur_b = rnd_op(0);
        cur_c = 1'($urandom_range(0, 1)); cur_s = 1'($urandom_range(0, 1));
      end
      c++;
    end
    vectors++; if (got !== 10) begin miscompares++; $display("FAIL bp_count got %0d want 10", got); end
    tiv[0] = 1'b0; tordy[0] = 1'b1;
  endtask

  task automatic test_reset_midstream();
    tordy[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tiv[0] = 1'b1; ta[0] = 64'(k + 100); tbv[0] = 64'(k + 1); tci[0] = 1'b0; tsub[0] = 1'b0;
      #1;
      tick();
    end
    tiv[0] = 1'b0; tordy[0] = 1'b0;
    #1;
    tick();
    #1;
    vectors++; if (ov[0] !== 1'b1) begin miscompares++; $display("FAIL mid_first_arrived got %b want 1", ov[0]); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL mid_async_drop got %b want 0", ov[0]); end
    vectors++; if (sm[0] !== 64'd0) begin miscompares++; $display("FAIL mid_async_sum got %h want 0", sm[0]); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) sbq[i].delete();
    tordy[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      vectors++; if (ov[0] !== 1'b0) begin miscompares++; $display("FAIL mid_discarded cycle %0d got valid %b want 0", k, ov[0]); end
    end
    test_single("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
  endtask

  task automatic test_sweep();
    int   sent [NI];
    logic acc  [NI];
    logic adv_b, busy;
    int   c;
    exp_t e;
    for (int i = 0; i < NI; i++) sent[i] = 0;
    c = 0; busy = 1'b1;
    while (busy && c < 60000) begin
      for (int i = 0; i < NI; i++) begin
        tiv[i]   = (sent[i] < NSW) && ($urandom_range(0, 3) != 0);
        ta[i]    = rnd_op(i);
        tbv[i]   = rnd_op(i);
        tci[i]   = 1'($urandom_range(0, 1));
        tsub[i]  = 1'($urandom_range(0, 1));
        tordy[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        adv_b = !ov[i] || tordy[i];
        vectors++; if (ir[i] !== adv_b) begin miscompares++; $display("FAIL sw%0d_in_ready cycle %0d got %b want %b", wd[i], c, ir[i], adv_b); end
        if (ov[i] && tordy[i]) begin
          vectors++;
          if (sbq[i].size() == 0) begin
            miscompares++; $display("FAIL sw%0d_spurious cycle %0d got %h want none", wd[i], c, sm[i]);
          end else begin
            e = sbq[i].pop_front();
            if ({sm[i], co[i], ofl[i]} !== {e.sum, e.cout, e.ovf}) begin
              miscompares++;
              $display("FAIL sw%0d_result cycle %0d got s=%h c=%b o=%b want s=%h c=%b o=%b",
                       wd[i], c, sm[i], co[i], ofl[i], e.sum, e.cout, e.ovf);
            end
            vectors++; if (adv_cnt[i] !== e.tag) begin miscompares++; $display("FAIL sw%0d_latency cycle %0d got adv %0d want %0d", wd[i], c, adv_cnt[i], e.tag); end
          end
        end
        acc[i] = tiv[i] && adv_b;
      end
      tick();
      busy = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (acc[i]) sent[i]++;
        if (sent[i] < NSW || sbq[i].size() > 0) busy = 1'b1;
      end
      c++;
    end
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (sent[i] !== NSW || sbq[i].size() !== 0) begin
        miscompares++;
        $display("FAIL sw%0d_complete got sent=%0d pending=%0d want sent=%0d pending=0", wd[i], sent[i], sbq[i].size(), NSW);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    wd[0] = 32; wd[1] = 8; wd[2] = 16; wd[3] = 64;
    st[0] = 4;  st[1] = 1; st[2] = 2;  st[3] = 8;
    for (int i = 0; i < NI; i++) begin
      tiv[i] = 1'b0; tordy[i] = 1'b1; ta[i] = '0; tbv[i] = '0; tci[i] = 1'b0; tsub[i] = 1'b0;
      adv_cnt[i] = 0;
    end
    rst_n = 1'b0;
    test_reset();
    test_latency();
    test_carry();
    test_subtract();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
